// File: rtl/display_pkg.sv
// Shared constants and helpers for the display row loader / capture pair.
package display_pkg;

    localparam int DEF_COLUMNS = 32;
    localparam int DEF_LANES   = 1;

    // Width needed to hold a column count in the range 0..columns.
    function automatic int col_idx_w(input int columns);
        return (columns < 1) ? 1 : $clog2(columns + 1);
    endfunction

endpackage

// File: rtl/display_row_capture_if.sv
// Row-load bus between the serial loader (master) and the panel-side capture (slave).
interface display_row_capture_if
    import display_pkg::*;
#(
    parameter int columns = DEF_COLUMNS,
    parameter int lanes   = DEF_LANES
);
    localparam int CW = col_idx_w(columns);

    logic                       oclk;
    logic [lanes-1:0]           sdata;
    logic                       latch;
    logic [columns*lanes-1:0]   row_data;
    logic                       row_valid;
    logic                       err_short;
    logic                       err_over;
    logic [CW-1:0]              bit_count;

    modport master (
        output oclk, sdata, latch,
        input  row_data, row_valid, err_short, err_over, bit_count
    );

    modport slave (
        input  oclk, sdata, latch,
        output row_data, row_valid, err_short, err_over, bit_count
    );

endinterface

// File: rtl/display_edge_detect.sv
// Rising-edge detector on a clk-synchronous level; the history flop keeps tracking
// the input during reset so a level held high across release gives no edge.
module display_edge_detect (
    input  logic clk,
    input  logic in_sig,
    output logic rise
);
    logic in_q;
    logic in_d;

    always_comb begin
        in_d = in_sig;
    end

    always_ff @(posedge clk) begin
        in_q <= in_d;
    end

    assign rise = in_sig & ~in_q;

endmodule

// File: rtl/display_row_capture.sv
// Panel-side column shift register and output latch: shifts sdata on oclk edges,
// transfers the row on a latch edge and flags short / overlong rows.
module display_row_capture
    import display_pkg::*;
#(
    parameter int columns = DEF_COLUMNS,
    parameter int lanes   = DEF_LANES
) (
    input  logic                 clk,
    input  logic                 rst,
    display_row_capture_if.slave bus
);
    localparam int W  = columns * lanes;
    localparam int CW = col_idx_w(columns);
    localparam logic [CW-1:0] CNT_MAX = CW'(columns);

    logic oclk_rise;
    logic latch_rise;

    display_edge_detect u_oclk_edge  (.clk(clk), .in_sig(bus.oclk),  .rise(oclk_rise));
    display_edge_detect u_latch_edge (.clk(clk), .in_sig(bus.latch), .rise(latch_rise));

    logic [W-1:0]  shreg_q, shreg_d;
    logic [W-1:0]  row_q, row_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovr_q, ovr_d;
    logic          valid_q, valid_d;
    logic          err_short_q, err_short_d;
    logic          err_over_q, err_over_d;

    // The latch sees the post-shift state, so a coincident oclk edge lands in the row.
    always_comb begin
        shreg_d     = shreg_q;
        row_d       = row_q;
        cnt_d       = cnt_q;
        ovr_d       = ovr_q;
        valid_d     = 1'b0;
        err_short_d = err_short_q;
        err_over_d  = err_over_q;

        if (oclk_rise) begin
            shreg_d = (shreg_q >> lanes) | (W'(bus.sdata) << (W - lanes));
            if (cnt_q == CNT_MAX) ovr_d = 1'b1;
            else                  cnt_d = cnt_q + 1'b1;
        end

        if (latch_rise) begin
            row_d       = shreg_d;
            err_short_d = (cnt_d < CNT_MAX);
            err_over_d  = ovr_d;
            valid_d     = 1'b1;
            cnt_d       = '0;
            ovr_d       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q     <= '0;
            row_q       <= '0;
            cnt_q       <= '0;
            ovr_q       <= 1'b0;
            valid_q     <= 1'b0;
            err_short_q <= 1'b0;
            err_over_q  <= 1'b0;
        end else begin
            shreg_q     <= shreg_d;
            row_q       <= row_d;
            cnt_q       <= cnt_d;
            ovr_q       <= ovr_d;
            valid_q     <= valid_d;
            err_short_q <= err_short_d;
            err_over_q  <= err_over_d;
        end
    end

    assign bus.row_data  = row_q;
    assign bus.row_valid = valid_q;
    assign bus.err_short = err_short_q;
    assign bus.err_over  = err_over_q;
    assign bus.bit_count = cnt_q;

endmodule

// File: tb/tb_display_row_capture.sv
// Directed bench for display_row_capture: single-lane rows plus one 6-lane instance.
module tb_display_row_capture;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    display_row_capture_if #(.columns(32), .lanes(1)) bus1 ();
    display_row_capture_if #(.columns(32), .lanes(6)) bus6 ();

    display_row_capture #(.columns(32), .lanes(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    display_row_capture #(.columns(32), .lanes(6)) dut6 (.clk(clk), .rst(rst), .bus(bus6));

    int n_chk  = 0;
    int n_fail = 0;
    int vcnt1  = 0;
    int vcnt6  = 0;
    int v0;

    always @(posedge clk) begin
        if (bus1.row_valid) vcnt1 <= vcnt1 + 1;
        if (bus6.row_valid) vcnt6 <= vcnt6 + 1;
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic shift1(input logic b);
        bus1.oclk  = 1'b1;
        bus1.sdata = b;
        tick();
        bus1.oclk  = 1'b0;
        tick();
    endtask

    task automatic shift_word(input logic [63:0] v, input int n);
        for (int i = 0; i < n; i++) shift1(v[i]);
    endtask

    task automatic latch_rise;
        bus1.latch = 1'b1;
        tick();
    endtask

    task automatic latch_fall;
        bus1.latch = 1'b0;
        tick();
    endtask

    logic [191:0] exp6;

    initial begin
        bus1.oclk = 1'b0; bus1.sdata = '0; bus1.latch = 1'b0;
        bus6.oclk = 1'b0; bus6.sdata = '0; bus6.latch = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();

        chk("rst_row_data",  bus1.row_data,  0);
        chk("rst_row_valid", bus1.row_valid, 0);
        chk("rst_err_short", bus1.err_short, 0);
        chk("rst_err_over",  bus1.err_over,  0);
        chk("rst_bit_count", bus1.bit_count, 0);

        // Nominal 32-bit row
        v0 = vcnt1;
        shift_word(64'hA5A5F00F, 32);
        chk("nom_count_pre", bus1.bit_count, 32);
        latch_rise();
        chk("nom_valid",     bus1.row_valid, 1);
        chk("nom_row",       bus1.row_data,  32'hA5A5F00F);
        chk("nom_err_short", bus1.err_short, 0);
        chk("nom_err_over",  bus1.err_over,  0);
        chk("nom_count",     bus1.bit_count, 0);
        latch_fall();
        chk("nom_valid_drop", bus1.row_valid, 0);
        chk("nom_pulses",    vcnt1 - v0, 1);

        // Short row: 31 new bits behind the old bit 31 of 0xA5A5F00F
        v0 = vcnt1;
        shift_word(64'h12345678, 31);
        latch_rise();
        chk("short_err_short", bus1.err_short, 1);
        chk("short_err_over",  bus1.err_over,  0);
        chk("short_row",       bus1.row_data,  32'h2468ACF1);
        // Back-to-back: oclk edge in the cycle right after the latch edge
        bus1.latch = 1'b0;
        bus1.oclk  = 1'b1;
        bus1.sdata = 1'b1;
        tick();
        chk("b2b_count", bus1.bit_count, 1);
        chk("short_pulses", vcnt1 - v0, 1);
        bus1.oclk = 1'b0;
        tick();
        shift_word(64'h0F0F0F0F >> 1, 31);
        latch_rise();
        chk("b2b_row",         bus1.row_data,  32'h0F0F0F0F);
        chk("b2b_err_short",   bus1.err_short, 0);
        latch_fall();

        // Overlong row: 34 edges, bit_count saturates
        shift_word(64'h3_1234_ABCD, 32);
        chk("over_count32", bus1.bit_count, 32);
        shift1(1'b1); shift1(1'b1);
        chk("over_count_sat", bus1.bit_count, 32);
        latch_rise();
        chk("over_err_over",  bus1.err_over,  1);
        chk("over_err_short", bus1.err_short, 0);
        chk("over_row",       bus1.row_data,  32'hC48D2AF3);
        latch_fall();
        chk("over_err_hold",  bus1.err_over,  1);

        // 32nd oclk edge coincident with latch edge; latch then held 5 cycles
        v0 = vcnt1;
        shift_word(64'h89ABCDEF, 31);
        bus1.oclk  = 1'b1;
        bus1.sdata = 1'b1;
        bus1.latch = 1'b1;
        tick();
        chk("same_valid",     bus1.row_valid, 1);
        chk("same_row",       bus1.row_data,  32'h89ABCDEF);
        chk("same_err_short", bus1.err_short, 0);
        chk("same_err_over",  bus1.err_over,  0);
        chk("same_count",     bus1.bit_count, 0);
        bus1.oclk = 1'b0;
        tick(); tick(); tick(); tick();
        latch_fall();
        chk("same_pulses", vcnt1 - v0, 1);

        // Latch with nothing shifted captures the stale register
        latch_rise();
        chk("stale_row",       bus1.row_data,  32'h89ABCDEF);
        chk("stale_err_short", bus1.err_short, 1);
        latch_fall();

        // Reset mid-row with oclk held high across release
        shift_word(64'hFFFFFFFF, 10);
        bus1.oclk = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("rst_mid_count", bus1.bit_count, 0);
        chk("rst_mid_row",   bus1.row_data,  0);
        chk("rst_mid_err",   bus1.err_short, 0);
        bus1.oclk = 1'b0;
        tick();
        shift_word(64'hFFFF0000, 32);
        latch_rise();
        chk("rst_row",       bus1.row_data,  32'hFFFF0000);
        chk("rst_err_short2", bus1.err_short, 0);
        chk("rst_err_over2",  bus1.err_over,  0);
        latch_fall();

        // Six lanes: column k carries value k
        v0 = vcnt6;
        for (int k = 0; k < 32; k++) begin
            bus6.oclk  = 1'b1;
            bus6.sdata = 6'(k);
            tick();
            bus6.oclk  = 1'b0;
            tick();
        end
        chk("ml_count", bus6.bit_count, 32);
        for (int k = 0; k < 32; k++) exp6[k*6 +: 6] = 6'(k);
        bus6.latch = 1'b1;
        tick();
        chk("ml_valid",     bus6.row_valid, 1);
        chk("ml_row",       bus6.row_data,  exp6);
        chk("ml_err_short", bus6.err_short, 0);
        chk("ml_err_over",  bus6.err_over,  0);
        bus6.latch = 1'b0;
        tick();
        chk("ml_pulses", vcnt6 - v0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/display_row_capture.md
# display_row_capture

Receive-side counterpart of the display row loader: a cycle-accurate model of the panel's column shift register and output latch. It samples the serial column data on each oclk rising edge and counts the bits. On a latch pulse it transfers the shifted row to a parallel output register and flags short or overlong rows. It sits on the panel side of the row-load interface, in loopback self-test and in the display-controller bench.

## Interface
Parameters:
- columns, 32, number of column bits per row
- lanes, 1, number of parallel serial data lines shifted per oclk (6 for dual-scan RGB)

Ports:
- clk  in  1  system clock; oclk and latch are generated synchronously to it
- rst  in  1  synchronous, active-high reset
- oclk  in  1  serial shift clock, at most half the clk rate
- sdata  in  lanes  serial column data, valid in the cycle oclk rises
- latch  in  1  row latch strobe, level or 1-cycle pulse
- row_data  out  columns*lanes  latched row; column k at row_data[k*lanes +: lanes]
- row_valid  out  1  1-cycle pulse, row_data updated
- err_short  out  1  last latched row had fewer than columns shifts
- err_over  out  1  last latched row had more than columns shifts
- bit_count  out  $clog2(columns+1)  shifts since last latch, saturating at columns

## Operation
- Rising-edge detection on oclk and latch, using registered copies oclk_q and latch_q.
- oclk edge: the shift register shifts right by lanes and inserts sdata at the top. After exactly columns shifts, the first bit shifted is at column 0.
  - bit_count increments and saturates at columns.
  - An edge while bit_count == columns sets the internal overrun flag.
- latch edge:
  - row_data <= the shift register value, including any shift in the same cycle.
  - err_short <= (bit_count after the same-cycle shift) < columns.
  - err_over <= overrun flag, including any same-cycle overrun.
  - row_valid <= 1.
  - bit_count and overrun are cleared. The shift register is NOT cleared, matching the panel hardware.
- err_short and err_over hold until the next latch edge.
- oclk and latch are level-sampled only; there are no glitch filters.
- No state machine beyond the counter and flags; idle and shifting are the same state.

## Timing
- Reset values:
  - row_data = 0, row_valid = 0, err_short = 0, err_over = 0, bit_count = 0, shift register = 0, overrun = 0.
  - During rst, oclk_q <= oclk and latch_q <= latch. An input held high across reset release therefore creates no edge.
- oclk edge at posedge t (oclk = 1, oclk_q = 0): the shift and bit_count update are visible after posedge t.
- latch edge at posedge t: row_data, row_valid, err_short and err_over are visible after posedge t. row_valid drops after posedge t+1. Latency from latch rising to row_valid is 1 clk.
- Simultaneous oclk and latch edge: the shift happens first, and the latched data includes that bit. bit_count is 0 afterwards, not 1.
- latch held high for many cycles produces exactly one capture.
- A latch edge with bit_count == 0 captures the stale shift register, with err_short = 1.
- Reset mid-row discards partial bits and flags. row_data returns to 0.
- Back-to-back rows: an oclk edge in the cycle after a latch counts toward the new row.

## Structure
- Shared package display_pkg: the column-index width function and the default columns/lanes constants used by the loader.
- One natural sub-module, display_edge_detect: a registered rising-edge detector with the reset-tracking behaviour above. It is instantiated twice, for oclk and latch.
- Expected size is 120–200 lines of RTL.

## Test plan
- Nominal row: columns=32, lanes=1. Drive the loader waveform (oclk toggling every 2 clk) with bits of 0xA5A5F00F, LSB first, then a 1-cycle latch. Required: row_data = 0xA5A5F00F, one row_valid pulse, both errors 0, bit_count 0 afterwards.
- Short row: 31 oclk edges, then latch. Required: err_short = 1, err_over = 0, row_valid pulses once. A following 32-bit row clears err_short.
- Overlong row: 34 edges with bits 0..33 = pattern P, then latch. Required: err_over = 1, row_data = bits 2..33, bit_count reads 32 before the latch.
- Same-cycle edge: 32nd oclk edge coincident with the latch edge. Required: err_short = 0, row_data includes bit 31, bit_count = 0 afterwards. Latch held high 5 cycles gives a single row_valid.
- Reset:
  - Run 10 shifts, assert rst for 1 cycle while oclk = 1, then run 32 shifts of 0xFFFF0000 and latch. Required: no spurious shift at release, row_data = 0xFFFF0000, no errors.
- Multi-lane: lanes=6. Shift 32 columns of column-index values (mod 64), then latch. Required: row_data[k*6 +: 6] = k for all k.
